vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 sync generator. Produces horizontal/vertical timing, sync pulses, active-video flag and pixel coordinates for any mode defined by per-axis active/porch/sync widths. Adds an internal pixel-clock-enable divider, a freeze enable, programmable sync polarity, line/frame start strobes and fully registered, mutually aligned outputs. Sits between the system clock domain and the pixel/colour pipeline feeding the VGA connector.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level (0 = active-low)
CLK_DIV, 1, system clocks per pixel tick (>=1)
COUNT_W, 10, width of x/y counters; H_TOTAL and V_TOTAL must be <= 2^COUNT_W

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
en  input  1  run enable; low freezes divider, counters and all outputs
pix_tick  output  1  one-clk pulse, high on cycles where the pixel position advances
hsync  output  1  horizontal sync, level per H_POL
vsync  output  1  vertical sync, level per V_POL
video_on  output  1  high while (x,y) is inside the active area
line_start  output  1  high for one pixel tick when x==0
frame_start  output  1  high for one pixel tick when x==0 and y==0
x  output  COUNT_W  current horizontal position
y  output  COUNT_W  current vertical position

Behaviour:
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 default); V_TOTAL likewise (525 default).
- Divider: div_cnt 0..CLK_DIV-1, advances only when en=1; tick when en=1 and div_cnt==CLK_DIV-1, div_cnt wraps to 0. CLK_DIV=1 -> tick every cycle en=1. pix_tick is registered, asserted in the same cycle the position outputs change.
- On tick: x increments; x==H_TOTAL-1 -> x=0 and y increments; y==V_TOTAL-1 with x wrap -> y=0. No other wrap points.
- All outputs registered, decoded from next-state (x,y), so hsync/vsync/video_on/strobes are aligned with x/y the same cycle; zero decode latency, glitch-free.
- hsync active iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; vsync active iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (defaults 656..751, 490..491). Inactive level = ~POL.
- video_on = (x < H_ACTIVE) && (y < V_ACTIVE).
- line_start/frame_start: high from the tick that lands on x==0 (resp. x==0,y==0) until the next tick; clear otherwise. In CLK_DIV>1 they therefore last CLK_DIV clocks; consumers qualify with pix_tick.
- Reset (async assert, any time, including mid-frame): div_cnt=0, x=H_TOTAL-1, y=V_TOTAL-1, hsync=~H_POL, vsync=~V_POL, video_on=0, line_start=0, frame_start=0, pix_tick=0. First tick after release lands on (0,0) with frame_start=1, line_start=1, video_on=1.
- en=0: everything holds including div_cnt; pix_tick=0; strobes hold their value. en re-asserted resumes exactly where stopped.
- Simultaneous en drop and reset: reset wins.

Test Plan:
1. Defaults, CLK_DIV=1, en=1 after reset -> first tick x=0,y=0,frame_start=1; hsync low exactly for x=656..751 (96 ticks); line period 800 clocks; vsync low for lines 490,491 (1600 clocks).
2. Defaults, count frame_start pulses over 2 frames -> spacing exactly 420000 clocks; video_on high count per frame = 307200.
3. CLK_DIV=4 -> pix_tick every 4th clk; x steps every 4 clocks; line period 3200 clocks; frame_start held 4 clocks.
4. H_POL=1,V_POL=1, small mode (H 8/2/2/4, V 4/1/1/2) -> hsync high only x=10..11, vsync high only y=5; wraps at x=15, y=7.
5. en low at x=300,y=100 for 50 clocks -> x,y,hsync,vsync constant, pix_tick=0; resume continues at x=301.
6. reset_n pulsed low at x=700,y=491 -> immediate reset values (syncs inactive, video_on=0); first tick after release gives (0,0), frame_start=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-tick divider, freeze enable, programmable
// sync polarity, line/frame strobes; every output registered and aligned with x/y.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CLK_DIV  = 1,
    parameter int COUNT_W  = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    output logic               pix_tick,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [COUNT_W-1:0] x,
    output logic [COUNT_W-1:0] y
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW1     = COUNT_W + 1;

    localparam logic [COUNT_W-1:0] X_LAST = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] Y_LAST = COUNT_W'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Decode bounds carry one extra bit so a boundary equal to 2^COUNT_W cannot alias to 0.
    localparam logic [CW1-1:0] X_VIS    = CW1'(H_ACTIVE);
    localparam logic [CW1-1:0] Y_VIS    = CW1'(V_ACTIVE);
    localparam logic [CW1-1:0] HS_BEGIN = CW1'(H_ACTIVE + H_FP);
    localparam logic [CW1-1:0] HS_END   = CW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW1-1:0] VS_BEGIN = CW1'(V_ACTIVE + V_FP);
    localparam logic [CW1-1:0] VS_END   = CW1'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    logic [DIV_W-1:0]   div_cnt;
    logic               tick;
    logic [COUNT_W-1:0] x_nxt;
    logic [COUNT_W-1:0] y_nxt;
    logic [CW1-1:0]     xw;
    logic [CW1-1:0]     yw;

    always_comb begin
        tick  = en && (div_cnt == DIV_LAST);
        x_nxt = (x == X_LAST) ? '0 : x + 1'b1;
        y_nxt = y;
        if (x == X_LAST) begin
            y_nxt = (y == Y_LAST) ? '0 : y + 1'b1;
        end
        xw = {1'b0, x_nxt};
        yw = {1'b0, y_nxt};
    end

    // Outputs are decoded from the next position so they land together with x/y.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            x           <= X_LAST;
            y           <= Y_LAST;
            pix_tick    <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_tick <= tick;
            if (en) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            end
            if (tick) begin
                x           <= x_nxt;
                y           <= y_nxt;
                hsync       <= ((xw >= HS_BEGIN) && (xw < HS_END)) ? HS_ON : ~HS_ON;
                vsync       <= ((yw >= VS_BEGIN) && (yw < VS_END)) ? VS_ON : ~VS_ON;
                video_on    <= (xw < X_VIS) && (yw < Y_VIS);
                line_start  <= (x_nxt == '0);
                frame_start <= (x_nxt == '0) && (y_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three modes run side by side against an arithmetic model
// of position-from-tick-count, plus directed literal checks on key timing points.
module tb_vga_timing_gen;
    localparam int ND = 3;
    localparam int HA [ND] = '{640, 8, 20};
    localparam int HF [ND] = '{16, 2, 2};
    localparam int HS [ND] = '{96, 2, 3};
    localparam int HB [ND] = '{48, 4, 5};
    localparam int VA [ND] = '{480, 4, 10};
    localparam int VF [ND] = '{10, 1, 2};
    localparam int VS [ND] = '{2, 1, 2};
    localparam int VB [ND] = '{33, 2, 3};
    localparam int HP [ND] = '{0, 1, 0};
    localparam int VP [ND] = '{0, 1, 1};
    localparam int DV [ND] = '{1, 1, 4};

    typedef struct {
        int x; int y; int hs; int vs; int vo; int ls; int fs; int pt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn0, rn1, rn2, en0, en1, en2;
    logic pt0, hs0, vs0, vo0, ls0, fs0;
    logic pt1, hs1, vs1, vo1, ls1, fs1;
    logic pt2, hs2, vs2, vo2, ls2, fs2;
    logic [9:0] x0, y0;
    logic [3:0] x1, y1;
    logic [5:0] x2, y2;

    logic [ND-1:0] rn_v, en_v, pt_v, hs_v, vs_v, vo_v, ls_v, fs_v;
    int ox [ND];
    int oy [ND];

    assign rn_v = {rn2, rn1, rn0};
    assign en_v = {en2, en1, en0};
    assign pt_v = {pt2, pt1, pt0};
    assign hs_v = {hs2, hs1, hs0};
    assign vs_v = {vs2, vs1, vs0};
    assign vo_v = {vo2, vo1, vo0};
    assign ls_v = {ls2, ls1, ls0};
    assign fs_v = {fs2, fs1, fs0};

    always_comb begin
        ox[0] = int'(x0); oy[0] = int'(y0);
        ox[1] = int'(x1); oy[1] = int'(y1);
        ox[2] = int'(x2); oy[2] = int'(y2);
    end

    vga_timing_gen u_d0 (
        .clk(clk), .reset_n(rn0), .en(en0), .pix_tick(pt0), .hsync(hs0), .vsync(vs0),
        .video_on(vo0), .line_start(ls0), .frame_start(fs0), .x(x0), .y(y0));

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .H_POL(1), .V_POL(1), .CLK_DIV(1), .COUNT_W(4)
    ) u_d1 (
        .clk(clk), .reset_n(rn1), .en(en1), .pix_tick(pt1), .hsync(hs1), .vsync(vs1),
        .video_on(vo1), .line_start(ls1), .frame_start(fs1), .x(x1), .y(y1));

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(5),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .H_POL(0), .V_POL(1), .CLK_DIV(4), .COUNT_W(6)
    ) u_d2 (
        .clk(clk), .reset_n(rn2), .en(en2), .pix_tick(pt2), .hsync(hs2), .vsync(vs2),
        .video_on(vo2), .line_start(ls2), .frame_start(fs2), .x(x2), .y(y2));

    // Enabled clock edges since reset release, and whether the latest edge was a tick.
    int ecnt [ND];
    int etk  [ND];
    always @(posedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (!rn_v[k]) begin
                ecnt[k] = 0;
                etk[k]  = 0;
            end else if (en_v[k]) begin
                ecnt[k] = ecnt[k] + 1;
                etk[k]  = ((ecnt[k] % DV[k]) == 0) ? 1 : 0;
            end else begin
                etk[k] = 0;
            end
        end
    end

    function automatic exp_t model(input int k, input int e, input int tk, input bit in_rst);
        exp_t r;
        int ht, vt, t, p, hin, vin;
        ht = HA[k] + HF[k] + HS[k] + HB[k];
        vt = VA[k] + VF[k] + VS[k] + VB[k];
        t  = e / DV[k];
        if (in_rst || t == 0) begin
            r.x = ht - 1; r.y = vt - 1;
            r.hs = (HP[k] == 0) ? 1 : 0;
            r.vs = (VP[k] == 0) ? 1 : 0;
            r.vo = 0; r.ls = 0; r.fs = 0; r.pt = 0;
        end else begin
            p   = t - 1;
            r.x = p % ht;
            r.y = (p / ht) % vt;
            hin = (r.x >= HA[k] + HF[k] && r.x < HA[k] + HF[k] + HS[k]) ? 1 : 0;
            vin = (r.y >= VA[k] + VF[k] && r.y < VA[k] + VF[k] + VS[k]) ? 1 : 0;
            r.hs = (hin == HP[k]) ? 1 : 0;
            r.vs = (vin == VP[k]) ? 1 : 0;
            r.vo = (r.x < HA[k] && r.y < VA[k]) ? 1 : 0;
            r.ls = (r.x == 0) ? 1 : 0;
            r.fs = (r.x == 0 && r.y == 0) ? 1 : 0;
            r.pt = tk;
        end
        return r;
    endfunction

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        exp_t m;
        for (int k = 0; k < ND; k++) begin
            m = model(k, ecnt[k], etk[k], !rn_v[k]);
            chk($sformatf("d%0d.x", k), ox[k], m.x);
            chk($sformatf("d%0d.y", k), oy[k], m.y);
            chk($sformatf("d%0d.hsync", k), int'(hs_v[k]), m.hs);
            chk($sformatf("d%0d.vsync", k), int'(vs_v[k]), m.vs);
            chk($sformatf("d%0d.video_on", k), int'(vo_v[k]), m.vo);
            chk($sformatf("d%0d.line_start", k), int'(ls_v[k]), m.ls);
            chk($sformatf("d%0d.frame_start", k), int'(fs_v[k]), m.fs);
            chk($sformatf("d%0d.pix_tick", k), int'(pt_v[k]), m.pt);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_all();
        end
    endtask

    int nfs [ND], clks [ND], vo_t [ND], vs_c [ND], fs_c [ND], pt_c [ND], hs_t [ND];
    int xmax [ND], ymax [ND];
    int hxmin, hxmax, vymin, vymax;
    int n, hs_low, mn, mx;

    initial begin
        rn0 = 0; rn1 = 0; rn2 = 0;
        en0 = 0; en1 = 0; en2 = 0;
        step(3);
        chk("rst.x0", ox[0], 799);
        chk("rst.y0", oy[0], 524);
        chk("rst.hsync0", int'(hs0), 1);
        chk("rst.video_on0", int'(vo0), 0);
        chk("rst.x1", ox[1], 15);
        chk("rst.hsync1", int'(hs1), 0);
        chk("rst.vsync2", int'(vs2), 0);

        rn0 = 1; rn1 = 1; rn2 = 1;
        en0 = 1; en1 = 1; en2 = 1;
        step(1);
        chk("first.x0", ox[0], 0);
        chk("first.y0", oy[0], 0);
        chk("first.frame_start0", int'(fs0), 1);
        chk("first.line_start0", int'(ls0), 1);
        chk("first.video_on0", int'(vo0), 1);
        chk("first.pix_tick0", int'(pt0), 1);
        chk("first.pix_tick2_early", int'(pt2), 0);
        step(3);
        chk("first.pix_tick2", int'(pt2), 1);
        chk("first.x2", ox[2], 0);
        chk("first.frame_start2", int'(fs2), 1);

        // freeze mid-line and resume
        for (int i = 0; i < 1000 && ox[0] != 300; i++) step(1);
        chk("reach.x0", ox[0], 300);
        en0 = 0;
        step(50);
        chk("hold.x0", ox[0], 300);
        chk("hold.y0", oy[0], 0);
        chk("hold.pix_tick0", int'(pt0), 0);
        chk("hold.hsync0", int'(hs0), 1);
        en0 = 1;
        step(1);
        chk("resume.x0", ox[0], 301);
        chk("resume.pix_tick0", int'(pt0), 1);

        // one full line: period and hsync window
        for (int i = 0; i < 2000 && !(ls0 && pt0 && oy[0] == 1); i++) step(1);
        chk("line1.found", oy[0], 1);
        n = 0; hs_low = 0; mn = 9999; mx = -1;
        do begin
            if (!hs0) begin
                hs_low++;
                if (ox[0] < mn) mn = ox[0];
                if (ox[0] > mx) mx = ox[0];
            end
            step(1);
            n++;
        end while (!(ls0 && pt0) && n < 2000);
        chk("line.period", n, 800);
        chk("line.hsync_ticks", hs_low, 96);
        chk("line.hsync_first", mn, 656);
        chk("line.hsync_last", mx, 751);
        chk("line.next_y", oy[0], 2);

        // asynchronous reset mid-line inside the sync pulse
        for (int i = 0; i < 1000 && ox[0] != 700; i++) step(1);
        chk("pre_rst.hsync0", int'(hs0), 0);
        @(posedge clk);
        #2 rn0 = 0;
        #1;
        chk("arst.x0", ox[0], 799);
        chk("arst.y0", oy[0], 524);
        chk("arst.hsync0", int'(hs0), 1);
        chk("arst.vsync0", int'(vs0), 1);
        chk("arst.video_on0", int'(vo0), 0);
        step(2);
        rn0 = 1;
        step(1);
        chk("post_rst.x0", ox[0], 0);
        chk("post_rst.y0", oy[0], 0);
        chk("post_rst.frame_start0", int'(fs0), 1);

        // whole-frame statistics for the two small modes
        for (int k = 0; k < ND; k++) begin
            nfs[k] = 0; clks[k] = 0; vo_t[k] = 0; vs_c[k] = 0;
            fs_c[k] = 0; pt_c[k] = 0; hs_t[k] = 0; xmax[k] = 0; ymax[k] = 0;
        end
        hxmin = 99; hxmax = -1; vymin = 99; vymax = -1;
        for (int i = 0; i < 6000 && !(nfs[1] >= 2 && nfs[2] >= 2); i++) begin
            step(1);
            for (int k = 1; k < ND; k++) begin
                if (fs_v[k] && pt_v[k]) nfs[k]++;
                if (nfs[k] == 1) begin
                    clks[k]++;
                    if (vo_v[k] && pt_v[k]) vo_t[k]++;
                    if (int'(vs_v[k]) == VP[k]) vs_c[k]++;
                    if (fs_v[k]) fs_c[k]++;
                    if (pt_v[k]) pt_c[k]++;
                    if (int'(hs_v[k]) == HP[k] && pt_v[k]) hs_t[k]++;
                    if (ox[k] > xmax[k]) xmax[k] = ox[k];
                    if (oy[k] > ymax[k]) ymax[k] = oy[k];
                    if (k == 1 && hs1) begin
                        if (ox[1] < hxmin) hxmin = ox[1];
                        if (ox[1] > hxmax) hxmax = ox[1];
                    end
                    if (k == 1 && vs1) begin
                        if (oy[1] < vymin) vymin = oy[1];
                        if (oy[1] > vymax) vymax = oy[1];
                    end
                end
            end
        end
        chk("d1.frame_clks", clks[1], 128);
        chk("d1.video_ticks", vo_t[1], 32);
        chk("d1.vsync_clks", vs_c[1], 16);
        chk("d1.fs_clks", fs_c[1], 1);
        chk("d1.ticks", pt_c[1], 128);
        chk("d1.hsync_ticks", hs_t[1], 16);
        chk("d1.xmax", xmax[1], 15);
        chk("d1.ymax", ymax[1], 7);
        chk("d1.hsync_xmin", hxmin, 10);
        chk("d1.hsync_xmax", hxmax, 11);
        chk("d1.vsync_ymin", vymin, 5);
        chk("d1.vsync_ymax", vymax, 5);
        chk("d2.frame_clks", clks[2], 2040);
        chk("d2.video_ticks", vo_t[2], 200);
        chk("d2.vsync_clks", vs_c[2], 240);
        chk("d2.fs_clks", fs_c[2], 4);
        chk("d2.ticks", pt_c[2], 510);
        chk("d2.hsync_ticks", hs_t[2], 51);
        chk("d2.xmax", xmax[2], 29);
        chk("d2.ymax", ymax[2], 16);

        // reset and enable drop together: reset wins
        step(37);
        rn2 = 0; en2 = 0;
        step(1);
        chk("rst_en.x2", ox[2], 29);
        chk("rst_en.y2", oy[2], 16);
        chk("rst_en.vsync2", int'(vs2), 0);
        rn2 = 1;
        step(4);
        chk("rst_en.hold_x2", ox[2], 29);
        en2 = 1;
        step(4);
        chk("rst_en.first_x2", ox[2], 0);
        chk("rst_en.first_fs2", int'(fs2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
